// File: rtl/count_sink.sv
// Checking tail for counter-driven designs: buffers accepted counter values in a FIFO and
// verifies drained values step by +1. Define COUNT_SINK_TRACE_EN to trace pops and stop on done.
module count_sink #(
   parameter int unsigned WIDTH = 32,
   parameter int unsigned DEPTH = 4,
   parameter int unsigned LIMIT = 5
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     in_valid,
   input  logic [WIDTH-1:0]         in_data,
   output logic                     in_ready,
   input  logic                     pop_en,
   output logic [WIDTH-1:0]         last_val,
   output logic [$clog2(DEPTH):0]   level,
   output logic                     err,
   output logic [7:0]               err_count,
   output logic                     done
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned LW = AW + 1;

   localparam logic [LW-1:0]    LvlFull = LW'(DEPTH);
   localparam logic [LW-1:0]    LvlOne  = LW'(1);
   localparam logic [AW-1:0]    PtrOne  = AW'(1);
   localparam logic [15:0]      AccLim  = 16'(LIMIT);
   localparam logic [WIDTH-1:0] ValOne  = WIDTH'(1);

   localparam logic [1:0] StRun   = 2'd0;
   localparam logic [1:0] StDrain = 2'd1;
   localparam logic [1:0] StDone  = 2'd2;

   logic [1:0]       state_q, state_d;
   logic [15:0]      acc_q, acc_d;
   logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
   logic [LW-1:0]    level_q, level_d;
   logic [WIDTH-1:0] last_val_q, last_val_d;
   logic             err_q, err_d;
   logic [7:0]       err_count_q, err_count_d;
   logic             primed_q, primed_d;
   logic [WIDTH-1:0] mem_q [DEPTH];

   logic             push, pop, mismatch;
   logic [WIDTH-1:0] rd_data;

   assign in_ready = (state_q == StRun) && (level_q != LvlFull);
   assign push     = in_valid && in_ready;
   assign pop      = pop_en && (level_q != '0) && (state_q != StDone);
   assign rd_data  = mem_q[rd_ptr_q];
   // The first pop after reset only establishes the expected sequence.
   assign mismatch = pop && primed_q && (rd_data != last_val_q + ValOne);

   always_comb begin
      state_d     = state_q;
      acc_d       = acc_q;
      wr_ptr_d    = wr_ptr_q;
      rd_ptr_d    = rd_ptr_q;
      level_d     = level_q;
      last_val_d  = last_val_q;
      err_d       = err_q;
      err_count_d = err_count_q;
      primed_d    = primed_q;

      if (push) begin
         wr_ptr_d = wr_ptr_q + PtrOne;
         acc_d    = acc_q + 16'd1;
      end

      if (pop) begin
         rd_ptr_d   = rd_ptr_q + PtrOne;
         last_val_d = rd_data;
         primed_d   = 1'b1;
         if (mismatch) begin
            err_d = 1'b1;
            if (err_count_q != 8'hFF) err_count_d = err_count_q + 8'd1;
         end
      end

      case ({push, pop})
         2'b10:   level_d = level_q + LvlOne;
         2'b01:   level_d = level_q - LvlOne;
         default: level_d = level_q;
      endcase

      case (state_q)
         StRun:   if (push && (acc_q + 16'd1 == AccLim)) state_d = StDrain;
         StDrain: if (level_q == '0) state_d = StDone;
         StDone:  state_d = StDone;
         default: state_d = StRun;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= StRun;
         acc_q       <= '0;
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         level_q     <= '0;
         last_val_q  <= '0;
         err_q       <= 1'b0;
         err_count_q <= '0;
         primed_q    <= 1'b0;
      end else begin
         state_q     <= state_d;
         acc_q       <= acc_d;
         wr_ptr_q    <= wr_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
         level_q     <= level_d;
         last_val_q  <= last_val_d;
         err_q       <= err_d;
         err_count_q <= err_count_d;
         primed_q    <= primed_d;
      end
   end

   // Storage needs no reset: pointers and level define what is valid.
   always_ff @(posedge clk) begin
      if (push) mem_q[wr_ptr_q] <= in_data;
   end

`ifdef COUNT_SINK_TRACE_EN
   always_ff @(posedge clk) begin
      if (!rst) begin
         if (pop) $write("%0d", rd_data);
         if (state_q == StDrain && state_d == StDone) $finish;
      end
   end
`else
   // Untraced build: no simulation side effects.
`endif

   assign last_val  = last_val_q;
   assign level     = level_q;
   assign err       = err_q;
   assign err_count = err_count_q;
   assign done      = (state_q == StDone);

endmodule

// File: tb/tb_count_sink.sv
// Bench for count_sink: queue-based reference model plus a pop scoreboard checked by a monitor.
module tb_count_sink;

   localparam int W = 32;
   localparam int D = 4;
   localparam int L = 5;

   logic         clk = 1'b0;
   logic         rst = 1'b1;
   logic         in_valid = 1'b0;
   logic [W-1:0] in_data = '0;
   logic         pop_en = 1'b0;
   logic         in_ready;
   logic [W-1:0] last_val;
   logic [2:0]   level;
   logic         err;
   logic [7:0]   err_count;
   logic         done;

   count_sink #(.WIDTH(W), .DEPTH(D), .LIMIT(L)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_data   (in_data),
      .in_ready  (in_ready),
      .pop_en    (pop_en),
      .last_val  (last_val),
      .level     (level),
      .err       (err),
      .err_count (err_count),
      .done      (done)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_pass   = 0;

   function automatic void chk(string name, logic [63:0] act, logic [63:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
   endfunction

   typedef struct {
      logic [W-1:0] val;
      logic         err;
      logic [7:0]   cnt;
   } rec_t;

   rec_t         sb[$];
   logic [W-1:0] m_fifo[$];
   int           m_acc, m_cnt;
   bit           m_closed, m_done, m_primed, m_err;
   logic [W-1:0] m_last;

   task automatic model_reset();
      chk("sb_drained", sb.size(), 0);
      sb.delete();
      m_fifo.delete();
      m_acc = 0; m_cnt = 0;
      m_closed = 0; m_done = 0; m_primed = 0; m_err = 0;
      m_last = '0;
   endtask

   task automatic check_outputs();
      chk("in_ready", in_ready, (!m_closed && m_fifo.size() < D));
      chk("level", level, m_fifo.size());
      chk("done", done, m_done);
      chk("last_val", last_val, m_last);
      chk("err", err, m_err);
      chk("err_count", err_count, m_cnt);
   endtask

   // Entered on a negedge; checks current outputs, drives one cycle, advances the model.
   task automatic step(input bit v, input logic [W-1:0] d, input bit p, output bit accepted);
      bit ready, push, pop, to_done;
      logic [W-1:0] val, nxt;
      check_outputs();
      in_valid = v; in_data = d; pop_en = p;
      ready   = !m_closed && (m_fifo.size() < D);
      push    = v && ready;
      pop     = p && (m_fifo.size() > 0) && !m_done;
      to_done = m_closed && !m_done && (m_fifo.size() == 0);
      if (pop) begin
         val = m_fifo.pop_front();
         nxt = m_last + 1'b1;
         if (m_primed && val != nxt) begin
            m_err = 1;
            if (m_cnt < 255) m_cnt++;
         end
         m_last = val;
         m_primed = 1;
         sb.push_back('{val: val, err: m_err, cnt: 8'(m_cnt)});
      end
      if (push) begin
         m_fifo.push_back(d);
         m_acc++;
         if (m_acc == L) m_closed = 1;
      end
      if (to_done) m_done = 1;
      accepted = push;
      @(negedge clk);
   endtask

   task automatic do_reset();
      rst = 1'b1; in_valid = 1'b0; pop_en = 1'b0;
      @(negedge clk);
      rst = 1'b0;
      model_reset();
   endtask

   task automatic run_until_done(input int budget);
      bit a;
      for (int i = 0; i < budget && !m_done; i++) step(0, '0, 1, a);
      chk("done_within_budget", done, 1);
   endtask

   // Monitor: whenever the DUT pops, the next scoreboard record must match.
   rec_t mon_r;
   always @(posedge clk) begin
      if (!rst && pop_en && level != 0 && !done) begin
         #1;
         if (sb.size() == 0) begin
            chk("unexpected_pop", 1, 0);
         end else begin
            mon_r = sb.pop_front();
            chk("sb_last_val", last_val, mon_r.val);
            chk("sb_err", err, mon_r.err);
            chk("sb_err_count", err_count, mon_r.cnt);
         end
      end
   end

   initial begin
      bit a;
      logic [W-1:0] cnt;
      logic [W-1:0] d;
      @(negedge clk);
      do_reset();

      // Back-to-back 0..4 with draining.
      for (int i = 0; i < 5; i++) step(1, W'(i), 1, a);
      run_until_done(10);
      chk("seq_no_err", err, 0);

      // Fill with pop disabled, then one pop frees a slot.
      do_reset();
      for (int i = 0; i < 6; i++) step(1, W'(i), 0, a);
      step(0, '0, 1, a);
      step(0, '0, 0, a);
      step(1, W'(4), 0, a);
      run_until_done(12);

      // Gap in the sequence: one error at 10.
      do_reset();
      begin
         logic [W-1:0] vals [5];
         vals = '{32'd7, 32'd8, 32'd10, 32'd11, 32'd12};
         for (int i = 0; i < 5; i++) step(1, vals[i], 1, a);
      end
      run_until_done(10);
      chk("gap_err", err, 1);
      chk("gap_err_count", err_count, 1);

      // All-ones wraps to zero legally.
      do_reset();
      cnt = 32'hFFFF_FFFE;
      for (int i = 0; i < 5; i++) begin
         step(1, cnt, 1, a);
         cnt = cnt + 1'b1;
      end
      run_until_done(10);
      chk("wrap_no_err", err, 0);

      // Reset in DRAIN with two entries left.
      do_reset();
      for (int i = 0; i < 4; i++) step(1, W'(i), 0, a);
      step(0, '0, 1, a);
      step(1, W'(4), 0, a);
      step(0, '0, 1, a);
      step(0, '0, 1, a);
      chk("pre_rst_level", level, 2);
      do_reset();
      step(0, '0, 0, a);

      // Simultaneous push and pop hold level at two.
      do_reset();
      step(1, W'(0), 0, a);
      step(1, W'(1), 0, a);
      for (int i = 2; i < 5; i++) step(1, W'(i), 1, a);
      run_until_done(10);

      // Randomized episodes with occasional corrupted values and resets.
      for (int ep = 0; ep < 30; ep++) begin
         do_reset();
         cnt = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFFD : $urandom;
         for (int c = 0; c < 40; c++) begin
            d = ($urandom_range(0, 9) == 0) ? $urandom : cnt;
            if ($urandom_range(0, 59) == 0) do_reset();
            step($urandom_range(0, 3) != 0, d, $urandom_range(0, 1) == 1, a);
            if (a) cnt = d + 1'b1;
            if (m_done && $urandom_range(0, 3) == 0) break;
         end
         for (int c = 0; c < 12; c++) step(0, '0, 1, a);
      end

      step(0, '0, 0, a);
      chk("final_sb_empty", sb.size(), 0);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
